// File: rtl/video_pkg.sv
// Shared constants, types and helper functions for the video transmit core.
package video_pkg;

  // TMDS control tokens sent during blanking, indexed by {c1,c0}.
  localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

  // Width of the signed running disparity kept per channel.
  localparam int DISP_W = 5;

  // One axis of the video timing: active, front porch, sync and back porch.
  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } video_timing_t;

  // Full period of one timing axis.
  function automatic int timing_total(input video_timing_t t);
    return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
  endfunction

  // Control token for a 2-bit control word.
  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = CTRL_TOKEN_00;
      2'b01:   tok = CTRL_TOKEN_01;
      2'b10:   tok = CTRL_TOKEN_10;
      2'b11:   tok = CTRL_TOKEN_11;
      default: tok = CTRL_TOKEN_00;
    endcase
    return tok;
  endfunction

  // Number of ones in a byte.
  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, d[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: transition-minimising stage, DC balancing against a
// signed running disparity, and control-token insertion during blanking.
// The symbol and the disparity are registered together.
module tmds_channel_enc
  import video_pkg::*;
#(
  parameter logic [1:0] RST_CTRL = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       de,
  input  logic [1:0] ctrl,
  input  logic [7:0] data,
  output logic [9:0] tmds
);

  localparam logic signed [DISP_W-1:0] D_ZERO = DISP_W'(0);
  localparam logic signed [DISP_W-1:0] D_TWO  = DISP_W'(2);

  logic [3:0]               n1_data_s;
  logic                     use_xnor_s;
  logic [8:0]               qm_s;
  logic [3:0]               n1_qm_s;
  logic [3:0]               n0_qm_s;
  logic signed [DISP_W-1:0] bal_s;
  logic signed [DISP_W-1:0] disp_r;
  logic signed [DISP_W-1:0] disp_nxt_s;
  logic [9:0]               sym_s;
  logic [9:0]               tmds_r;

  assign n1_data_s  = popcount8(data);
  assign use_xnor_s = (n1_data_s > 4'd4) || ((n1_data_s == 4'd4) && (data[0] == 1'b0));

  // Chain XOR or XNOR through the byte; bit 8 records which one was used.
  always_comb begin
    qm_s    = 9'd0;
    qm_s[0] = data[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor_s) begin
        qm_s[i] = ~(qm_s[i-1] ^ data[i]);
      end else begin
        qm_s[i] = qm_s[i-1] ^ data[i];
      end
    end
    qm_s[8] = ~use_xnor_s;
  end

  assign n1_qm_s = popcount8(qm_s[7:0]);
  assign n0_qm_s = 4'd8 - n1_qm_s;
  // Ones minus zeros of the intermediate word, in disparity units.
  assign bal_s = $signed({{(DISP_W-4){1'b0}}, n1_qm_s}) - $signed({{(DISP_W-4){1'b0}}, n0_qm_s});

  // Pick inversion so the running disparity is pulled towards zero.
  always_comb begin
    sym_s      = 10'd0;
    disp_nxt_s = disp_r;
    if ((disp_r == D_ZERO) || (bal_s == D_ZERO)) begin
      sym_s = {~qm_s[8], qm_s[8], (qm_s[8] ? qm_s[7:0] : ~qm_s[7:0])};
      if (qm_s[8]) begin
        disp_nxt_s = disp_r + bal_s;
      end else begin
        disp_nxt_s = disp_r - bal_s;
      end
    end else if (((disp_r > D_ZERO) && (bal_s > D_ZERO)) ||
                 ((disp_r < D_ZERO) && (bal_s < D_ZERO))) begin
      sym_s      = {1'b1, qm_s[8], ~qm_s[7:0]};
      disp_nxt_s = disp_r + (qm_s[8] ? D_TWO : D_ZERO) - bal_s;
    end else begin
      sym_s      = {1'b0, qm_s[8], qm_s[7:0]};
      disp_nxt_s = disp_r - (qm_s[8] ? D_ZERO : D_TWO) + bal_s;
    end
  end

  // Register the symbol; blanking sends a control token and clears disparity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmds_r <= ctrl_token(RST_CTRL);
      disp_r <= D_ZERO;
    end else if (!de) begin
      tmds_r <= ctrl_token(ctrl);
      disp_r <= D_ZERO;
    end else begin
      tmds_r <= sym_s;
      disp_r <= disp_nxt_s;
    end
  end

  assign tmds = tmds_r;

endmodule

// File: rtl/video_tx_core.sv
// Video transmit core: raster timing generator, pixel capture with an
// optional colour-bar pattern, and three TMDS channel encoders.
// Pipeline: stage 0 timing registers, stage 1 capture registers (pixel
// input arrives combinationally one cycle after req), stage 2 encoders.
module video_tx_core
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COORD_W  = 11,
  parameter int BAR_W    = 80
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               pattern_en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               req,
  input  logic [7:0]         red,
  input  logic [7:0]         green,
  input  logic [7:0]         blue,
  output logic               frame_start,
  output logic [15:0]        frame_cnt,
  output logic [9:0]         tmds_r,
  output logic [9:0]         tmds_g,
  output logic [9:0]         tmds_b
);

  localparam video_timing_t H_TIM = '{active: 16'(H_ACTIVE), fp: 16'(H_FP),
                                      sync: 16'(H_SYNC), bp: 16'(H_BP)};
  localparam video_timing_t V_TIM = '{active: 16'(V_ACTIVE), fp: 16'(V_FP),
                                      sync: 16'(V_SYNC), bp: 16'(V_BP)};
  localparam int H_TOTAL = timing_total(H_TIM);
  localparam int V_TOTAL = timing_total(V_TIM);

  localparam logic [COORD_W-1:0] C_ZERO   = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] C_ONE    = COORD_W'(1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam int                BAR_CW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(BAR_W - 1);
  localparam logic [BAR_CW-1:0] BAR_ZERO = {BAR_CW{1'b0}};
  localparam logic [BAR_CW-1:0] BAR_ONE  = BAR_CW'(1);

  // Blue carries {vsync,hsync}; at reset both sit at their inactive level.
  localparam logic [1:0] BLUE_RST_CTRL = {~VS_POL, ~HS_POL};

  // Reset synchroniser
  logic [1:0] rst_sync_r;
  logic       rst_int_n_s;

  // Stage 0 state and next-state
  logic               run_r;
  logic [COORD_W-1:0] x_r, y_r;
  logic [COORD_W-1:0] x_nxt_s, y_nxt_s;
  logic               live_s, wrap_s;
  logic               req_r, fs_r, hs_r, vs_r;
  logic [15:0]        frame_cnt_r;
  logic [2:0]         bar_r, bar_nxt_s;
  logic [BAR_CW-1:0]  bar_cnt_r, bar_cnt_nxt_s;

  // Stage 1 state
  logic               de1_r, hs1_r, vs1_r;
  logic [2:0]         bar1_r;
  logic [7:0]         pix_r_s, pix_g_s, pix_b_s;

  // Assert reset asynchronously, release it two clean clock edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];

  // Raster position for the next cycle; the first enabled cycle starts at 0,0.
  always_comb begin
    x_nxt_s = C_ZERO;
    y_nxt_s = C_ZERO;
    live_s  = 1'b0;
    wrap_s  = 1'b0;
    if (!en) begin
      live_s = 1'b0;
    end else if (!run_r) begin
      live_s = 1'b1;
    end else begin
      live_s = 1'b1;
      if (x_r == H_LAST) begin
        x_nxt_s = C_ZERO;
        if (y_r == V_LAST) begin
          y_nxt_s = C_ZERO;
          wrap_s  = 1'b1;
        end else begin
          y_nxt_s = y_r + C_ONE;
        end
      end else begin
        x_nxt_s = x_r + C_ONE;
        y_nxt_s = y_r;
      end
    end
  end

  // Bar index follows the position: restarts each line, steps every BAR_W active pixels.
  always_comb begin
    bar_nxt_s     = 3'd0;
    bar_cnt_nxt_s = BAR_ZERO;
    if (live_s && (x_nxt_s != C_ZERO)) begin
      if (x_r < H_ACT_C) begin
        if (bar_cnt_r == BAR_LAST) begin
          bar_cnt_nxt_s = BAR_ZERO;
          bar_nxt_s     = bar_r + 3'd1;
        end else begin
          bar_cnt_nxt_s = bar_cnt_r + BAR_ONE;
          bar_nxt_s     = bar_r;
        end
      end else begin
        bar_cnt_nxt_s = bar_cnt_r;
        bar_nxt_s     = bar_r;
      end
    end else begin
      bar_cnt_nxt_s = BAR_ZERO;
      bar_nxt_s     = 3'd0;
    end
  end

  // Stage 0: register position, request, frame pulse, syncs and frame count.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      run_r       <= 1'b0;
      x_r         <= C_ZERO;
      y_r         <= C_ZERO;
      req_r       <= 1'b0;
      fs_r        <= 1'b0;
      hs_r        <= ~HS_POL;
      vs_r        <= ~VS_POL;
      frame_cnt_r <= 16'd0;
      bar_r       <= 3'd0;
      bar_cnt_r   <= BAR_ZERO;
    end else begin
      run_r     <= en;
      x_r       <= x_nxt_s;
      y_r       <= y_nxt_s;
      req_r     <= live_s && (x_nxt_s < H_ACT_C) && (y_nxt_s < V_ACT_C);
      fs_r      <= live_s && (x_nxt_s == C_ZERO) && (y_nxt_s == C_ZERO);
      hs_r      <= (live_s && (x_nxt_s >= HS_FIRST) && (x_nxt_s <= HS_LAST)) ? HS_POL : ~HS_POL;
      vs_r      <= (live_s && (y_nxt_s >= VS_FIRST) && (y_nxt_s <= VS_LAST)) ? VS_POL : ~VS_POL;
      bar_r     <= bar_nxt_s;
      bar_cnt_r <= bar_cnt_nxt_s;
      if (wrap_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  // Stage 1: delay control and bar index to line up with the returned pixel.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      de1_r  <= 1'b0;
      hs1_r  <= ~HS_POL;
      vs1_r  <= ~VS_POL;
      bar1_r <= 3'd0;
    end else begin
      de1_r  <= req_r;
      hs1_r  <= hs_r;
      vs1_r  <= vs_r;
      bar1_r <= bar_r;
    end
  end

  // Pixel source select, re-evaluated every pixel.
  always_comb begin
    if (pattern_en) begin
      pix_r_s = {8{bar1_r[2]}};
      pix_g_s = {8{bar1_r[1]}};
      pix_b_s = {8{bar1_r[0]}};
    end else begin
      pix_r_s = red;
      pix_g_s = green;
      pix_b_s = blue;
    end
  end

  tmds_channel_enc #(.RST_CTRL(2'b00)) u_enc_r (
    .clk   (clk),
    .rst_n (rst_int_n_s),
    .de    (de1_r),
    .ctrl  (2'b00),
    .data  (pix_r_s),
    .tmds  (tmds_r)
  );

  tmds_channel_enc #(.RST_CTRL(2'b00)) u_enc_g (
    .clk   (clk),
    .rst_n (rst_int_n_s),
    .de    (de1_r),
    .ctrl  (2'b00),
    .data  (pix_g_s),
    .tmds  (tmds_g)
  );

  tmds_channel_enc #(.RST_CTRL(BLUE_RST_CTRL)) u_enc_b (
    .clk   (clk),
    .rst_n (rst_int_n_s),
    .de    (de1_r),
    .ctrl  ({vs1_r, hs1_r}),
    .data  (pix_b_s),
    .tmds  (tmds_b)
  );

  assign x           = x_r;
  assign y           = y_r;
  assign req         = req_r;
  assign frame_start = fs_r;
  assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_video_tx_core.sv
// Scoreboard bench for video_tx_core. A reference model tracks the raster as
// a linear pixel index and encodes pixels with an integer TMDS model; each
// cycle's expected outputs are queued and a monitor compares them.
module tb_video_tx_core;

  localparam int HA = 16, HFP = 1, HSW = 2, HBP = 1;
  localparam int VA = 3,  VFP = 1, VSW = 1, VBP = 1;
  localparam int BW = 2,  CW = 11;
  localparam bit HSP = 1'b0, VSP = 1'b0;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int NCYC = 900;
  localparam int RST_AT = 420;
  localparam logic [9:0] TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  logic          clk, rst_n, en, pattern_en;
  logic [CW-1:0] x, y;
  logic          req, frame_start;
  logic [7:0]    red, green, blue;
  logic [15:0]   frame_cnt;
  logic [9:0]    tmds_r, tmds_g, tmds_b;

  video_tx_core #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .COORD_W(CW), .BAR_W(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern_en(pattern_en),
    .x(x), .y(y), .req(req),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .frame_cnt(frame_cnt),
    .tmds_r(tmds_r), .tmds_g(tmds_g), .tmds_b(tmds_b)
  );

  typedef struct {
    int x; int y; bit live; bit req; bit fs; bit hs; bit vs;
  } s0_t;

  typedef struct {
    int x; int y; bit req; bit fs; int fc;
    logic [9:0] tr; logic [9:0] tg; logic [9:0] tb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req_v, $time);
    end
  endtask

  function automatic s0_t idle_s0();
    s0_t s;
    s.x = 0; s.y = 0; s.live = 1'b0; s.req = 1'b0; s.fs = 1'b0; s.hs = 1'b0; s.vs = 1'b0;
    return s;
  endfunction

  // DVI TMDS reference with integer disparity.
  task automatic ref_enc(input bit de, input logic [1:0] c, input logic [7:0] d,
                         inout int dp, output logic [9:0] q);
    int n1d, n1, n0;
    bit xn;
    logic [8:0] qm;
    if (!de) begin
      q  = TOK[c];
      dp = 0;
    end else begin
      n1d   = $countones(d);
      xn    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm    = 9'd0;
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !xn;
      n1 = $countones(qm[7:0]);
      n0 = 8 - n1;
      if (dp == 0 || n1 == n0) begin
        q  = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
        dp = qm[8] ? dp + n1 - n0 : dp + n0 - n1;
      end else if ((dp > 0 && n1 > n0) || (dp < 0 && n0 > n1)) begin
        q  = {1'b1, qm[8], ~qm[7:0]};
        dp = dp + (qm[8] ? 2 : 0) + n0 - n1;
      end else begin
        q  = {1'b0, qm[8], qm[7:0]};
        dp = dp - (qm[8] ? 0 : 2) + n1 - n0;
      end
    end
  endtask

  // Stimulus and reference model: one expectation per upcoming clock edge.
  initial begin
    int   k, fc, hold, drop_left, bar;
    bit   run, dropped_once;
    s0_t  h1, h2, s;
    int   disp [3];
    exp_t e;
    logic [7:0] pr, pg, pb;
    logic [1:0] cb;

    k = 0; fc = 0; hold = 0; drop_left = 0; run = 1'b0; dropped_once = 1'b0;
    h1 = idle_s0(); h2 = idle_s0();
    disp[0] = 0; disp[1] = 0; disp[2] = 0;
    rst_n = 1'b0; en = 1'b0; pattern_en = 1'b0; red = 8'h00; green = 8'h00; blue = 8'h00;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rst_n = !(cyc < 4 || (cyc >= RST_AT && cyc < RST_AT + 2));

      if (cyc == RST_AT) begin
        #1;
        chk("rst_now_x", 32'(x), 32'd0);
        chk("rst_now_y", 32'(y), 32'd0);
        chk("rst_now_req", 32'(req), 32'd0);
        chk("rst_now_fcnt", 32'(frame_cnt), 32'd0);
        chk("rst_now_tmds_r", 32'(tmds_r), 32'h354);
        chk("rst_now_tmds_g", 32'(tmds_g), 32'h354);
        chk("rst_now_tmds_b", 32'(tmds_b), 32'h2AB);
      end

      if (cyc < 10) begin
        en = 1'b0;
      end else if (drop_left > 0) begin
        en = 1'b0;
        drop_left--;
      end else begin
        en = 1'b1;
        if (!dropped_once && cyc > 150 && h1.live && h1.x == 2 && h1.y == 1) begin
          en = 1'b0; dropped_once = 1'b1; drop_left = 2;
        end else if (cyc > RST_AT + 10 && $urandom_range(0, 99) == 0) begin
          en = 1'b0; drop_left = $urandom_range(0, 2);
        end
      end

      if ($urandom_range(0, 5) == 0) pattern_en = !pattern_en;
      red   = 8'(h2.x * 13 + h2.y * 7);
      green = 8'($urandom);
      blue  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);

      if (!rst_n || hold > 0) begin
        if (!rst_n) hold = 2; else hold--;
        k = 0; fc = 0; run = 1'b0; h1 = idle_s0(); h2 = idle_s0();
        disp[0] = 0; disp[1] = 0; disp[2] = 0;
        cb = {!VSP, !HSP};
        e.x = 0; e.y = 0; e.req = 1'b0; e.fs = 1'b0; e.fc = 0;
        e.tr = TOK[0]; e.tg = TOK[0]; e.tb = TOK[cb];
      end else begin
        s = idle_s0();
        if (en) begin
          if (!run) begin
            k = 0;
          end else begin
            k++;
            if (k == HT * VT) begin k = 0; fc = (fc + 1) % 65536; end
          end
          run = 1'b1;
          s.live = 1'b1; s.x = k % HT; s.y = k / HT; s.fs = (k == 0);
          s.req = (s.x < HA) && (s.y < VA);
          s.hs  = (s.x >= HA + HFP) && (s.x < HA + HFP + HSW);
          s.vs  = (s.y >= VA + VFP) && (s.y < VA + VFP + VSW);
        end else begin
          run = 1'b0;
        end

        if (pattern_en) begin
          bar = (h2.x / BW) % 8;
          pr = ((bar & 4) != 0) ? 8'hFF : 8'h00;
          pg = ((bar & 2) != 0) ? 8'hFF : 8'h00;
          pb = ((bar & 1) != 0) ? 8'hFF : 8'h00;
        end else begin
          pr = red; pg = green; pb = blue;
        end
        cb = {(h2.vs ? VSP : !VSP), (h2.hs ? HSP : !HSP)};
        ref_enc(h2.req, 2'b00, pr, disp[0], e.tr);
        ref_enc(h2.req, 2'b00, pg, disp[1], e.tg);
        ref_enc(h2.req, cb,    pb, disp[2], e.tb);
        h2 = h1;
        h1 = s;
        e.x = s.x; e.y = s.y; e.req = s.req; e.fs = s.fs; e.fc = fc;
      end
      exp_q.push_back(e);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: after each active edge, pop the expectation and compare outputs.
  initial begin
    exp_t m;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        chk("x", 32'(x), 32'(m.x));
        chk("y", 32'(y), 32'(m.y));
        chk("req", 32'(req), 32'(m.req));
        chk("frame_start", 32'(frame_start), 32'(m.fs));
        chk("frame_cnt", 32'(frame_cnt), 32'(m.fc));
        chk("tmds_r", 32'(tmds_r), 32'(m.tr));
        chk("tmds_g", 32'(tmds_g), 32'(m.tg));
        chk("tmds_b", 32'(tmds_b), 32'(m.tb));
      end
    end
  end

endmodule
